wb_resp_regs: RTL

Synthesizable Wishbone classic-cycle responder with a four-register command/status map (CSR, DPR, CMDR, FSMR) at 8-bit data width. It is the slave end of the Wishbone master BFM used across the I2CMB verification environment. It serves as a lightweight stand-in target for bring-up of wb agents, monitors and interrupt-handling sequences, independent of the full I2CMB DUT. Each accepted command runs a programmable busy period, then posts done/NACK status and an optional level interrupt.

---
 rtl/wb_resp_regs_if.sv | 16 +
 rtl/wb_resp_regs.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_resp_regs_if.sv
// Wishbone classic-cycle bus bundle between a master BFM and the wb_resp_regs responder.
interface wb_resp_regs_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;

  modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
  modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/wb_resp_regs.sv
// Wishbone responder with CSR/DPR/CMDR/FSMR map; each accepted command runs a fixed
// busy period, then posts done/NACK status and an optional level interrupt.
module wb_resp_regs #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0,
  parameter int CMD_LATENCY = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_resp_regs_if.slave wb,
  input  logic          nack_inject_i,
  output logic          irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       en_q, en_d;
  logic       ie_q, ie_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] cmd_q, cmd_d;
  logic       busy_q, busy_d;
  logic [7:0] lcnt_q, lcnt_d;
  logic       done_q, done_d;
  logic       nack_q, nack_d;
  logic       err_q, err_d;
  logic [4:0] ncmd_q, ncmd_d;
  logic       irq_q, irq_d;

  logic       req, acc, wr, rd;
  logic       sel_csr, sel_dpr, sel_cmdr, sel_fsmr;
  logic       abort;
  logic [7:0] wdat;
  logic [7:0] rdata;

  assign req  = wb.cyc_i & wb.stb_i;
  assign acc  = (state_q == S_ACK);
  assign wr   = acc & wb.we_i;
  assign rd   = acc & ~wb.we_i;
  assign wdat = wb.dat_i[7:0];

  assign sel_csr  = (wb.adr_i == ADDR_WIDTH'(0));
  assign sel_dpr  = (wb.adr_i == ADDR_WIDTH'(1));
  assign sel_cmdr = (wb.adr_i == ADDR_WIDTH'(2));
  assign sel_fsmr = (wb.adr_i == ADDR_WIDTH'(3));

  // Clearing E while a command is in flight kills it, even on its completion edge.
  assign abort = wr & sel_csr & ~wdat[7] & busy_q;

  // Bus FSM: DONE holds off a second ack while the master keeps its strobe up.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          wcnt_d  = 4'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (!req)              state_d = S_IDLE;
        else if (wcnt_q == '0) state_d = S_ACK;
        else                   wcnt_d  = wcnt_q - 4'd1;
      end
      S_ACK:   state_d = S_DONE;
      S_DONE:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register file and command engine; a completion set overrides a same-cycle read clear.
  always_comb begin
    en_d   = en_q;
    ie_d   = ie_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    cmd_d  = cmd_q;
    busy_d = busy_q;
    lcnt_d = lcnt_q;
    done_d = done_q;
    nack_d = nack_q;
    err_d  = err_q;
    ncmd_d = ncmd_q;
    irq_d  = done_q & ie_q;

    if (wr && sel_csr) begin
      en_d = wdat[7];
      ie_d = wdat[6];
    end
    if (wr && sel_dpr) tx_d = wdat;
    if (wr && sel_cmdr) begin
      if (en_q && !busy_q) begin
        cmd_d  = wdat[2:0];
        busy_d = 1'b1;
        lcnt_d = 8'(CMD_LATENCY);
      end else begin
        err_d = 1'b1;
      end
    end
    if (rd && sel_cmdr) begin
      done_d = 1'b0;
      nack_d = 1'b0;
      err_d  = 1'b0;
      irq_d  = 1'b0;
    end

    if (abort) begin
      busy_d = 1'b0;
      lcnt_d = '0;
    end else if (busy_q) begin
      if (lcnt_q == 8'd1) begin
        busy_d = 1'b0;
        lcnt_d = '0;
        done_d = 1'b1;
        nack_d = nack_inject_i;
        rx_d   = tx_q;
        ncmd_d = ncmd_q + 5'd1;
      end else begin
        lcnt_d = lcnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_csr)  rdata = {en_q, ie_q, 6'b0};
    if (sel_dpr)  rdata = rx_q;
    if (sel_cmdr) rdata = {done_q, nack_q, 1'b0, err_q, 1'b0, cmd_q};
    if (sel_fsmr) rdata = {busy_q, 2'b0, ncmd_q};
  end

  assign wb.ack_o = acc;
  assign wb.dat_o = acc ? DATA_WIDTH'(rdata) : '0;
  assign irq_o    = irq_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      lcnt_q  <= '0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
      ncmd_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      lcnt_q  <= lcnt_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
      ncmd_q  <= ncmd_d;
      irq_q   <= irq_d;
    end
  end

endmodule
